// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC sequencer: the op encoding.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BR_REL = 3'd1,
    PC_BR_ABS = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } pc_op_t;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO with synchronous clear. The top entry is readable combinationally.
module pc_return_stack #(
  parameter int PC_BITS     = 12,
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_BITS  = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [PC_BITS-1:0]    push_data,
  output logic [PC_BITS-1:0]    top,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS-1:0] depth
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_BITS-1:0] mem [STACK_DEPTH];
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   top_idx;

  assign full    = (depth == DEPTH_BITS'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign wr_idx  = IDX_W'(depth);
  assign top_idx = IDX_W'(depth - DEPTH_BITS'(1));
  assign top     = mem[top_idx];

  // Entries are not cleared; only the depth count defines what is valid.
  always_ff @(posedge clock) begin
    if (!clear && push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DEPTH_BITS'(1);
    end else if (pop && !empty) begin
      depth <= depth - DEPTH_BITS'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: PC register, next-PC mux, halt detection and sticky stack-error flag.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_BITS     = 12,
  parameter int OFF_BITS    = 8,
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_BITS  = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  start,
  input  logic                  nextIns,
  input  pc_op_t                op,
  input  logic                  take,
  input  logic [OFF_BITS-1:0]   offset,
  input  logic [PC_BITS-1:0]    target,
  input  logic [PC_BITS-1:0]    startingAddress,
  input  logic [PC_BITS-1:0]    doneAddress,
  output logic [PC_BITS-1:0]    pc_out,
  output logic                  done,
  output logic                  stackErr,
  output logic [DEPTH_BITS-1:0] stackDepth
);

  logic [PC_BITS-1:0] pc_seq;
  logic [PC_BITS-1:0] off_ext;
  logic [PC_BITS-1:0] pc_nxt;
  logic [PC_BITS-1:0] stk_top;
  logic               stk_full;
  logic               stk_empty;
  logic               push;
  logic               pop;
  logic               err_set;
  logic               done_nxt;

  assign pc_seq  = pc_out + PC_BITS'(1);
  assign off_ext = PC_BITS'(signed'(offset));

  // nextIns is a one-cycle advance strobe with no back-pressure: every edge
  // with nextIns=1 (and not halted or in start) consumes exactly one op.
  always_comb begin
    pc_nxt   = pc_out;
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
    done_nxt = done;
    if (done || (pc_out == doneAddress)) begin
      done_nxt = 1'b1;
    end else if (nextIns) begin
      case (op)
        PC_BR_REL: pc_nxt = take ? (pc_out + off_ext) : pc_seq;
        PC_BR_ABS: pc_nxt = take ? target : pc_seq;
        PC_CALL: begin
          if (!stk_full) begin
            push   = 1'b1;
            pc_nxt = target;
          end else begin
            pc_nxt  = pc_seq;
            err_set = 1'b1;
          end
        end
        PC_RET: begin
          if (!stk_empty) begin
            pop    = 1'b1;
            pc_nxt = stk_top;
          end else begin
            pc_nxt  = pc_seq;
            err_set = 1'b1;
          end
        end
        default: pc_nxt = pc_seq;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      pc_out   <= startingAddress;
      done     <= 1'b0;
      stackErr <= 1'b0;
    end else begin
      pc_out   <= pc_nxt;
      done     <= done_nxt;
      stackErr <= stackErr | err_set;
    end
  end

  pc_return_stack #(
    .PC_BITS    (PC_BITS),
    .STACK_DEPTH(STACK_DEPTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_stack (
    .clock    (clock),
    .clear    (start),
    .push     (push),
    .pop      (pop),
    .push_data(pc_seq),
    .top      (stk_top),
    .full     (stk_full),
    .empty    (stk_empty),
    .depth    (stackDepth)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int PC_BITS     = 12;
  localparam int OFF_BITS    = 8;
  localparam int STACK_DEPTH = 4;
  localparam int DEPTH_BITS  = $clog2(STACK_DEPTH + 1);

  // clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  start = 1'b0;
  logic                  nextIns = 1'b0;
  pc_op_t                op = PC_SEQ;
  logic                  take = 1'b0;
  logic [OFF_BITS-1:0]   offset = '0;
  logic [PC_BITS-1:0]    target = '0;
  logic [PC_BITS-1:0]    startingAddress = '0;
  logic [PC_BITS-1:0]    doneAddress = 12'h7FF;
  logic [PC_BITS-1:0]    pc_out;
  logic                  done;
  logic                  stackErr;
  logic [DEPTH_BITS-1:0] stackDepth;

  pc_sequencer #(
    .PC_BITS(PC_BITS), .OFF_BITS(OFF_BITS), .STACK_DEPTH(STACK_DEPTH), .DEPTH_BITS(DEPTH_BITS)
  ) dut (
    .clock(clock), .start(start), .nextIns(nextIns), .op(op), .take(take),
    .offset(offset), .target(target), .startingAddress(startingAddress),
    .doneAddress(doneAddress), .pc_out(pc_out), .done(done),
    .stackErr(stackErr), .stackDepth(stackDepth)
  );

  // scoreboard / reference model
  int checks = 0;
  int failures = 0;
  logic [PC_BITS-1:0] exp_q[$];
  logic [PC_BITS-1:0] m_pc = '0;
  logic               m_done = 1'b0;
  logic               m_err = 1'b0;

  function automatic logic [PC_BITS-1:0] wrap(int v);
    return PC_BITS'(v % (1 << PC_BITS) + (1 << PC_BITS));
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".pc"}, 32'(pc_out), 32'(m_pc));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".err"}, 32'(stackErr), 32'(m_err));
    check({tag, ".depth"}, 32'(stackDepth), exp_q.size());
  endtask

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic do_start(logic [PC_BITS-1:0] addr, string tag);
    start = 1'b1;
    startingAddress = addr;
    @(posedge clock);
    m_pc = addr; m_done = 1'b0; m_err = 1'b0; exp_q.delete();
    #1;
    start = 1'b0;
    check_all(tag);
  endtask

  task automatic step(logic nx, int code, logic tk, logic [OFF_BITS-1:0] off,
                      logic [PC_BITS-1:0] tgt, string tag);
    int soff;
    nextIns = nx; op = pc_op_t'(code); take = tk; offset = off; target = tgt;
    @(posedge clock);
    soff = (int'(off) >= (1 << (OFF_BITS - 1))) ? int'(off) - (1 << OFF_BITS) : int'(off);
    if (m_done || m_pc == doneAddress) begin
      m_done = 1'b1;
    end else if (nx) begin
      if (code == 1 && tk) m_pc = wrap(int'(m_pc) + soff);
      else if (code == 2 && tk) m_pc = tgt;
      else if (code == 3 && exp_q.size() < STACK_DEPTH) begin
        exp_q.push_back(wrap(int'(m_pc) + 1));
        m_pc = tgt;
      end else if (code == 4 && exp_q.size() > 0) m_pc = exp_q.pop_back();
      else begin
        if (code == 3 || code == 4) m_err = 1'b1;
        m_pc = wrap(int'(m_pc) + 1);
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // sequential fetch
    do_start(12'h010, "rst");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "seq");

    // relative branches, taken backwards and not taken
    step(1, 2, 1, 0, 12'h020, "abs");
    step(1, 1, 1, 8'hFC, 0, "rel_taken");
    step(1, 2, 1, 0, 12'h020, "abs2");
    step(1, 1, 0, 8'hFC, 0, "rel_not");
    step(1, 1, 1, 8'h80, 0, "rel_min");

    // wrap
    do_start(12'hFFF, "rst_fff");
    step(1, 0, 0, 0, 0, "wrap");
    step(1, 1, 1, 8'hFE, 0, "rel_wrap");

    // call / return, back-to-back
    do_start(12'h100, "rst_100");
    step(1, 3, 0, 0, 12'h200, "call");
    step(1, 4, 0, 0, 0, "ret");

    // overflow with STACK_DEPTH+1 nested calls
    for (int i = 0; i <= STACK_DEPTH; i++) step(1, 3, 0, 0, 12'h300 + 12'(i * 16), "nest");
    for (int i = 0; i < 5; i++) step(0, 3, 1, 8'h05, 12'h123, "hold");
    step(1, 4, 0, 0, 0, "unwind");
    do_start(12'h400, "start_full");

    // underflow, sticky
    do_start(12'h050, "rst_050");
    step(1, 4, 0, 0, 0, "underflow");
    step(1, 0, 0, 0, 0, "err_sticky");
    step(1, 7, 1, 0, 12'h555, "undef_op");

    // halt
    doneAddress = 12'h014;
    do_start(12'h012, "rst_012");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "to_done");
    step(1, 2, 1, 0, 12'h321, "halt_abs");
    step(1, 3, 0, 0, 12'h321, "halt_call");
    do_start(12'h012, "rst_clear");
    do_start(12'h014, "rst_at_done");
    step(0, 0, 0, 0, 0, "start_eq_done");
    step(1, 0, 0, 0, 0, "still_done");

    // randomized phase
    for (int r = 0; r < 400; r++) begin
      if (r % 50 == 0) begin
        doneAddress = 12'($urandom_range(0, 4095));
        do_start(12'($urandom_range(0, 4095)), "rnd_rst");
      end
      step(logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
           logic'($urandom_range(0, 1)), 8'($urandom), 12'($urandom), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the core's fetch stage. It holds the PC register and advances it in sequence. It supports signed relative branches in both directions, absolute jumps, and call/return through an internal return-address stack. Halt is detected at a programmable done address, and stack misuse is reported through a sticky error flag.

## Interface
- PC_BITS, 12, PC and address width
- OFF_BITS, 8, signed relative-offset width (OFF_BITS ≤ PC_BITS)
- STACK_DEPTH, 4, return-stack entries (≥1)
- DEPTH_BITS, $clog2(STACK_DEPTH+1), width of stackDepth
- clock  in  1  sole clock, rising edge
- start  in  1  synchronous, active-high reset; loads startingAddress
- nextIns  in  1  advance enable; 0 holds all state
- op  in  3  pc_op_t: PC_SEQ, PC_BR_REL, PC_BR_ABS, PC_CALL, PC_RET
- take  in  1  branch condition for PC_BR_REL/PC_BR_ABS; ignored otherwise
- offset  in  OFF_BITS  signed relative displacement
- target  in  PC_BITS  absolute target for PC_BR_ABS/PC_CALL
- startingAddress  in  PC_BITS  PC value loaded on start
- doneAddress  in  PC_BITS  halt address
- pc_out  out  PC_BITS  current PC (registered)
- done  out  1  sticky halt flag
- stackErr  out  1  sticky overflow/underflow flag
- stackDepth  out  DEPTH_BITS  valid return-stack entries

## Operation
- Priority per edge: start > halted > nextIns > hold.
- start: pc_out←startingAddress, done←0, stackErr←0, stackDepth←0. Stack contents are don't-care.
- Halted: when pc_out==doneAddress at an edge without start, done←1 and pc_out holds. done stays 1, and all further ops are ignored, until start.
- nextIns=1, not halted, by op:
  - PC_SEQ: pc+1.
  - PC_BR_REL: take ? pc+sext(offset) : pc+1.
  - PC_BR_ABS: take ? target : pc+1.
  - PC_CALL: if stackDepth<STACK_DEPTH, push pc+1 and pc←target. If full, no push, pc←pc+1, stackErr←1.
  - PC_RET: if stackDepth>0, pop and pc←popped value. If empty, pc←pc+1, stackErr←1.
  - Undefined op codes behave as PC_SEQ.
- Arithmetic: all PC sums are modulo 2^PC_BITS and wrap silently. The offset is sign-extended to PC_BITS, so 0x80 with OFF_BITS=8 means −128.
- nextIns=0: pc_out, stack and flags hold.

## Timing
- All outputs are registered and change only on rising clock.
- Reset values: pc_out=startingAddress (sampled at the start edge), done=0, stackErr=0, stackDepth=0.
- Latency: the op sampled at edge N is visible on pc_out after edge N.
- done asserts one edge after pc_out first equals doneAddress.
- Reaching doneAddress by any path (seq, branch, call, ret) halts the sequencer.
- If startingAddress==doneAddress, done asserts on the first edge after start deasserts.
- start asserted mid-operation, including while halted or with a full stack, wins unconditionally on that edge.
- The stack pointer updates on the same edge as pc_out. A CALL immediately followed by a RET returns correctly with no bubble.

## Structure
- Package pc_pkg holds pc_op_t (3-bit enum) and its encodings, PC_SEQ=0 through PC_RET=4.
- Sub-module pc_return_stack is a LIFO of STACK_DEPTH×PC_BITS with push/pop/full/empty/depth and synchronous clear.
- The top level holds the PC register, the next-PC mux and the done/err flags.

## Test plan
- start with startingAddress=0x010, then 3×PC_SEQ → pc_out 0x010, 0x011, 0x012, 0x013; done=0.
- At pc=0x020, PC_BR_REL take=1 offset=0xFC → 0x01C. Same op with take=0 → 0x021. At pc=0xFFF, PC_SEQ → 0x000 (wrap).
- At pc=0x100, PC_CALL target=0x200 → pc 0x200, depth 1. Then PC_RET → 0x101, depth 0. With STACK_DEPTH+1 nested calls, the last call gives pc+1 and stackErr=1.
- PC_RET with depth 0 at pc=0x050 → pc 0x051, stackErr=1. The flag stays set until start.
- doneAddress=0x014, sequencing from 0x012 → pc reaches 0x014, done=1 the next edge. pc holds under further nextIns and ops. start then clears done.
- nextIns=0 for 5 cycles with op=PC_CALL → pc_out, stackDepth and flags unchanged.
